// File: rtl/spi_adc_pkg.sv
// Shared constants for the SPI ADC responder: frame length, control-word field
// positions, the normal power mode and the frame state encoding.
package spi_adc_pkg;

    localparam int FRAME_BITS = 16;

    localparam int WRITE_BIT  = 15;
    localparam int ADD_HI     = 12;
    localparam int ADD_LO     = 10;
    localparam int PM_HI      = 9;
    localparam int PM_LO      = 8;
    localparam int RANGE_BIT  = 5;
    localparam int CODING_BIT = 4;

    localparam logic [1:0]  PM_NORMAL = 2'b11;
    localparam logic [11:0] MSB_FLIP  = 12'h800;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer for one asynchronous input, with single-clock
// rise/fall pulses derived from the synchronized level.
module sync_edge #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic sync_out,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain_r;
    logic              prev_r;

    // Synchronizer chain plus one history flop for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain_r <= {STAGES{RESET_VAL}};
            prev_r  <= RESET_VAL;
        end else begin
            chain_r <= {chain_r[STAGES-2:0], async_in};
            prev_r  <= chain_r[STAGES-1];
        end
    end

    assign sync_out = chain_r[STAGES-1];
    assign rise     = chain_r[STAGES-1] & ~prev_r;
    assign fall     = ~chain_r[STAGES-1] & prev_r;

endmodule

// File: rtl/spi_adc_responder.sv
// SPI slave emulating a multi-channel ADC: returns {0, addr, data12} per frame
// and accepts a control word that reconfigures channel, power mode and coding.
module spi_adc_responder
    import spi_adc_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FRAME_BITS  = spi_adc_pkg::FRAME_BITS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cs_n,
    input  logic             sclk,
    input  logic             din,
    output logic             dout,
    input  logic [7:0][11:0] sample,
    output logic [2:0]       cur_addr,
    output logic [1:0]       pm,
    output logic             range_sel,
    output logic             coding,
    output logic             frame_done,
    output logic             frame_err
);

    localparam int CW = $clog2(FRAME_BITS + 1);

    logic cs_lvl_s, cs_rise_s, cs_fall_s;
    logic sclk_lvl_s, sclk_rise_s, sclk_fall_s;
    logic din_s, din_rise_s, din_fall_s;

    sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
        .clk(clk), .rst_n(rst_n), .async_in(cs_n),
        .sync_out(cs_lvl_s), .rise(cs_rise_s), .fall(cs_fall_s));
    sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .async_in(sclk),
        .sync_out(sclk_lvl_s), .rise(sclk_rise_s), .fall(sclk_fall_s));
    sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_din (
        .clk(clk), .rst_n(rst_n), .async_in(din),
        .sync_out(din_s), .rise(din_rise_s), .fall(din_fall_s));

    state_e                state_r, state_s;
    logic [FRAME_BITS-1:0] tx_r, tx_s, rx_r, rx_s, load_s;
    logic [CW-1:0]         cnt_r, cnt_s;
    logic                  dout_r, dout_s;
    logic [2:0]            addr_r, addr_s;
    logic [1:0]            pm_r, pm_s;
    logic                  range_r, range_s, coding_r, coding_s;
    logic                  done_r, done_s, err_r, err_s;
    logic [11:0]           data12_s;
    logic [FRAME_BITS+15:0] ext_s;
    logic                  last_edge_s;

    assign last_edge_s = sclk_fall_s && (cnt_r == CW'(FRAME_BITS - 1));

    // Conversion value presented at frame start; powered-down channels read zero.
    always_comb begin
        data12_s = 12'h000;
        if (pm_r != PM_NORMAL) begin
            data12_s = 12'h000;
        end else if (coding_r) begin
            data12_s = sample[addr_r];
        end else begin
            data12_s = sample[addr_r] ^ MSB_FLIP;
        end
        ext_s  = {1'b0, addr_r, data12_s, {FRAME_BITS{1'b0}}};
        load_s = ext_s[FRAME_BITS+15 -: FRAME_BITS];
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; a final edge coinciding with cs_n rise completes the frame.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE:  state_s = cs_fall_s ? ST_SHIFT : ST_IDLE;
            ST_SHIFT: begin
                if (last_edge_s) begin
                    state_s = ST_DONE;
                end else if (cs_rise_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_SHIFT;
                end
            end
            ST_DONE:  state_s = cs_rise_s ? ST_IDLE : ST_DONE;
            default:  state_s = ST_IDLE;
        endcase
    end

    // Datapath and output next-values per state.
    always_comb begin
        tx_s     = tx_r;
        rx_s     = rx_r;
        cnt_s    = cnt_r;
        dout_s   = 1'b0;
        addr_s   = addr_r;
        pm_s     = pm_r;
        range_s  = range_r;
        coding_s = coding_r;
        done_s   = 1'b0;
        err_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (cs_fall_s) begin
                    tx_s   = load_s;
                    rx_s   = {FRAME_BITS{1'b0}};
                    cnt_s  = {CW{1'b0}};
                    dout_s = load_s[FRAME_BITS-1];
                end else begin
                    dout_s = 1'b0;
                end
            end
            ST_SHIFT: begin
                if (sclk_fall_s) begin
                    rx_s  = {rx_r[FRAME_BITS-2:0], din_s};
                    tx_s  = {tx_r[FRAME_BITS-2:0], 1'b0};
                    cnt_s = cnt_r + CW'(1);
                    if (last_edge_s) begin
                        dout_s = 1'b0;
                        done_s = 1'b1;
                        if (rx_s[WRITE_BIT]) begin
                            addr_s   = rx_s[ADD_HI:ADD_LO];
                            pm_s     = rx_s[PM_HI:PM_LO];
                            range_s  = rx_s[RANGE_BIT];
                            coding_s = rx_s[CODING_BIT];
                        end else begin
                            addr_s = addr_r;
                        end
                    end else begin
                        dout_s = tx_r[FRAME_BITS-2];
                    end
                end else if (cs_rise_s) begin
                    err_s  = 1'b1;
                    dout_s = 1'b0;
                end else begin
                    dout_s = dout_r;
                end
            end
            ST_DONE: dout_s = 1'b0;
            default: dout_s = 1'b0;
        endcase
    end

    // Registered datapath, configuration and status pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_r     <= {FRAME_BITS{1'b0}};
            rx_r     <= {FRAME_BITS{1'b0}};
            cnt_r    <= {CW{1'b0}};
            dout_r   <= 1'b0;
            addr_r   <= 3'd0;
            pm_r     <= PM_NORMAL;
            range_r  <= 1'b0;
            coding_r <= 1'b1;
            done_r   <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            tx_r     <= tx_s;
            rx_r     <= rx_s;
            cnt_r    <= cnt_s;
            dout_r   <= dout_s;
            addr_r   <= addr_s;
            pm_r     <= pm_s;
            range_r  <= range_s;
            coding_r <= coding_s;
            done_r   <= done_s;
            err_r    <= err_s;
        end
    end

    assign dout       = dout_r;
    assign cur_addr   = addr_r;
    assign pm         = pm_r;
    assign range_sel  = range_r;
    assign coding     = coding_r;
    assign frame_done = done_r;
    assign frame_err  = err_r;

endmodule

// File: doc/spi_adc_responder.md
SPI_ADC_RESPONDER -- requirements
Module: spi_adc_responder

Interface
REQ-001 Parameter SYNC_STAGES, default 2, synchronizer depth on cs_n/sclk/din.
REQ-002 Parameter FRAME_BITS, default 16, SCLK falling edges per frame.
REQ-003 clk  input  1  system clock; all state on posedge clk; only clock.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 cs_n  input  1  frame select from ADC master, active-low, asynchronous.
REQ-006 sclk  input  1  serial clock from master, asynchronous; frequency at most clk/4.
REQ-007 din  input  1  control word from master, MSB first.
REQ-008 dout  output  1  conversion word to master, MSB first.
REQ-009 sample  input  8x12  per-channel conversion values, straight binary, sampled at frame start.
REQ-010 cur_addr  output  3  channel converted in the current/next frame.
REQ-011 pm, range_sel, coding  output  2/1/1  last written config fields.
REQ-012 frame_done  output  1  one-clk pulse after a complete frame.
REQ-013 frame_err  output  1  one-clk pulse when cs_n rises before FRAME_BITS edges.

Function
REQ-014 cs_n, sclk and din SHALL each pass through the SYNC_STAGES-flop synchronizer; edges are detected on the synchronized values.
REQ-015 States: IDLE, SHIFT, DONE; IDLE->SHIFT on cs_n fall; SHIFT->DONE on 16th sclk fall; SHIFT->IDLE on cs_n rise before that (pulse frame_err); DONE->IDLE on cs_n rise.
REQ-016 On cs_n fall: tx word = {1'b0, cur_addr, data12}; dout = tx[15] within 1 clk; edge counter cleared.
REQ-017 data12 = sample[cur_addr] if coding=1; sample[cur_addr] with bit 11 inverted if coding=0.
REQ-018 Each synchronized sclk falling edge in SHIFT: shift din into rx register LSB; advance dout to next tx bit; increment counter.
REQ-019 After the 16th falling edge dout SHALL be 0 until the next frame; in IDLE dout SHALL be 0.
REQ-020 On SHIFT->DONE: if rx[15] (WRITE)=1 load cur_addr=rx[12:10], pm=rx[9:8], range_sel=rx[5], coding=rx[4]; if WRITE=0 keep config; pulse frame_done.
REQ-021 Config updates SHALL take effect from the next frame only; the current tx word is unaffected.
REQ-022 If pm != 2'b11 at frame start, data12 SHALL be 0 (powered down); address bits still driven.
REQ-023 sclk edges while cs_n high SHALL be ignored; extra edges after the 16th SHALL be ignored.
REQ-024 Simultaneous cs_n rise and 16th sclk fall in the same clk: the frame counts as complete (DONE path, frame_done, no frame_err).
REQ-025 frame_err frame SHALL NOT update configuration.

Reset
REQ-026 rst_n low SHALL asynchronously force: state IDLE, dout=0, cur_addr=0, pm=2'b11, range_sel=0, coding=1, frame_done=0, frame_err=0, counter/rx/tx=0, synchronizers to idle (cs_n=1, sclk=1, din=0).
REQ-027 Reset mid-frame SHALL abort the frame with no config update and no pulse; the first frame after release is processed normally.

Structure
REQ-028 Shared package spi_adc_pkg: FRAME_BITS, control-field bit positions (WRITE, ADD, PM, RANGE, CODING), PM_NORMAL=2'b11, state enum.
REQ-029 One sub-module: sync_edge (synchronizer chain plus rise/fall pulse outputs), instantiated once per input.

Verification
REQ-030 Master writes 0x830_0 (WRITE=1, ADD=0, PM=11, coding=0) then reads with sample[0]=0x800 -> second frame dout = 0x0000 (bit 11 inverted), frame_done pulses twice.
REQ-031 Write ADD=5, coding=1, sample[5]=0xABC -> next frame dout = 0x5ABC, cur_addr=5.
REQ-032 cs_n rises after 9 sclk edges -> frame_err one pulse, cur_addr/pm/coding unchanged, dout=0.
REQ-033 Write PM=2'b00 ADD=3 -> next frame dout = 0x3000.
REQ-034 rst_n low at edge 8 of a WRITE frame -> outputs at reset values immediately, following frame uses cur_addr=0.
REQ-035 20 sclk edges in one frame, WRITE=0 -> exactly 16 bits shifted, frame_done once, config unchanged.
